l1_mem_bus_arbiter: RTL

- Shares the single L2/memory bus (mem_bus_req_t / mem_bus_resp_t) between two L1 caches: port 0 = instruction L1, port 1 = data L1.
- Grants one requester at a time and holds the grant for the whole transaction until the downstream mem_ready.
- Inserts a one-cycle release gap so neither side sees a stale request or ready. Alternates fairly when both caches miss.

---
 rtl/l1_mem_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/l1_mem_bus_arbiter.sv
// Two-port L1 -> L2 memory bus arbiter.
// Port 0 is the instruction L1 and port 1 is the data L1. One owner holds the
// bus from grant until the downstream mem_ready. A one-cycle RELEASE gap then
// lets the owner drop its request before anyone else is considered.
//
// Handshake: a port requests by raising mem_req_load or mem_req_store. It
// holds every request field stable until it samples mem_ready high on a rising
// edge, and it drops or changes the request after that edge. mem_ready is
// high for exactly one cycle per completed transaction. Requests are never
// latched here: a port that goes inactive while it is granted aborts its
// transaction.
//
// Watchdog: the counter clears on entry to GRANT. It then counts the GRANT
// cycles that end without mem_ready. timeout_err registers on the edge where
// the count reaches TIMEOUT_CYCLES, which closes the TIMEOUT_CYCLES-th such
// cycle. The flag stays set until reset, and the grant is never revoked.

package l1_mem_bus_pkg;
  typedef struct packed {
    logic        mem_req_load;
    logic        mem_req_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
  } mem_bus_req_t;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_data;
  } mem_bus_resp_t;
endpackage

module l1_mem_bus_arbiter
  import l1_mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  mem_bus_req_t  req0,
  output mem_bus_resp_t resp0,
  input  mem_bus_req_t  req1,
  output mem_bus_resp_t resp1,
  output mem_bus_req_t  mem_req,
  input  mem_bus_resp_t mem_resp,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          timeout_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);

  state_t               r_state, w_state_nx;
  logic                 r_rr_ptr, w_rr_ptr_nx;
  logic [1:0]           r_grant, w_grant_nx;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic                 r_timeout, w_timeout_nx;

  logic                 w_act0, w_act1;
  logic                 w_pick;
  logic                 w_gidx;
  logic                 w_gact;
  mem_bus_req_t         w_greq;

  assign w_act0 = req0.mem_req_load | req0.mem_req_store;
  assign w_act1 = req1.mem_req_load | req1.mem_req_store;
  // A tie goes to rr_ptr. Otherwise the only active port wins.
  assign w_pick = (w_act0 & w_act1) ? r_rr_ptr : w_act1;
  assign w_gidx = r_grant[1];
  assign w_greq = w_gidx ? req1 : req0;
  assign w_gact = w_greq.mem_req_load | w_greq.mem_req_store;

  assign grant       = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout;
  assign dbg_state   = r_state;

  // State, round-robin pointer, owner, watchdog counter and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= 1'b0;
      r_grant   <= 2'b00;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rr_ptr  <= w_rr_ptr_nx;
      r_grant   <= w_grant_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  // Next state plus bus steering. Outside GRANT the downstream request and
  // both readies are held at zero.
  always_comb begin
    w_state_nx     = r_state;
    w_rr_ptr_nx    = r_rr_ptr;
    w_grant_nx     = r_grant;
    w_cnt_nx       = r_cnt;
    w_timeout_nx   = r_timeout;
    mem_req        = '0;
    resp0          = '0;
    resp1          = '0;
    resp0.mem_data = mem_resp.mem_data;
    resp1.mem_data = mem_resp.mem_data;
    case (r_state)
      ST_IDLE: begin
        w_grant_nx = 2'b00;
        if (w_act0 | w_act1) begin
          w_grant_nx = w_pick ? 2'b10 : 2'b01;
          w_cnt_nx   = '0;
          w_state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        mem_req = w_greq;
        if (w_gidx) resp1.mem_ready = mem_resp.mem_ready;
        else        resp0.mem_ready = mem_resp.mem_ready;
        if (mem_resp.mem_ready) begin
          // The port that just finished yields the next tie.
          w_rr_ptr_nx = ~w_gidx;
          w_state_nx  = ST_RELEASE;
        end else begin
          if (r_cnt != TO_LIMIT) w_cnt_nx = r_cnt + CNT_ONE;
          if (WD_EN && (w_cnt_nx == TO_LIMIT)) w_timeout_nx = 1'b1;
          if (!w_gact) begin
            // Abort: the owner withdrew, so rr_ptr keeps its value.
            w_grant_nx = 2'b00;
            w_state_nx = ST_IDLE;
          end
        end
      end
      ST_RELEASE: begin
        w_grant_nx = 2'b00;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_grant_nx = 2'b00;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
